serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor computing `o_diff = i_a - i_b` one bit per clock, LSB first. It is the inverse-direction companion to the team's combinational `BITS`-wide adder and uses the same operand width parameter. Its signed-overflow flag follows the adder's sign-bit rule, and it also reports an unsigned borrow. It trades latency for a single one-bit subtract cell and sits in the arithmetic datapath wherever area matters more than throughput.

## Interface
- `BITS`, 4, operand and result width; legal range 2..32.
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  start request; sampled only when `o_busy`=0.
- `i_a`  in  BITS  minuend; sampled with an accepted `i_start`.
- `i_b`  in  BITS  subtrahend; sampled with an accepted `i_start`.
- `o_busy`  out  1  high while a subtraction is in progress.
- `o_done`  out  1  one-cycle pulse when the result registers update.
- `o_diff`  out  BITS  result `(i_a - i_b) mod 2^BITS`; held between operations.
- `o_borrow`  out  1  unsigned borrow: `i_a < i_b` as unsigned.
- `o_overflow`  out  1  signed overflow of `i_a - i_b`.

## Operation
- FSM states:
  - IDLE → CALC on accepted `i_start`.
  - CALC → DONE when the bit counter reaches `BITS-1`.
  - DONE → IDLE unconditionally, unless `i_start`=1, in which case DONE → CALC.
- Start is accepted when `i_start`=1 in IDLE or DONE. On acceptance:
  - latch `i_a` into shift register A and `i_b` into shift register B;
  - load `{A_msb, B_msb}` into a sign register;
  - clear the bit counter and the borrow flop.
- Each CALC cycle, with `a`=A[0], `b`=B[0], `bw`=borrow flop:
  - `d = a ^ b ^ bw`
  - `bw_next = (~a & b) | (~(a ^ b) & bw)`
  - `d` is shifted into the MSB of result shift register R. A and B shift right.
- DONE-entry update, in the same edge as CALC → DONE:
  - `o_diff` ← final R, including the last bit;
  - `o_borrow` ← final `bw_next`;
  - `o_overflow` ← (`a_sign != b_sign`) & (`diff_msb != a_sign`).
- `o_diff`, `o_borrow` and `o_overflow` change only on that edge. They hold their previous values during CALC.
- `i_start` while in CALC is ignored. No queueing, no error flag.
- `i_a` and `i_b` are don't-care except in the cycle where start is accepted.
- Bit counter is `$clog2(BITS)` bits wide and never wraps inside an operation.

## Timing
- Reset values: state IDLE, `o_busy`=0, `o_done`=0, `o_diff`=0, `o_borrow`=0, `o_overflow`=0. Shift registers, counter and borrow flop are cleared.
- Start sampled at edge E0. `o_busy`=1 from E0 through E0+BITS, i.e. for BITS cycles.
- Results and `o_done`=1 are visible after edge E0+BITS. `o_done` drops after the next edge unless a new operation completes there.
- Latency is BITS+1 cycles from start to done.
- Back-to-back throughput: a new operation can start every BITS+1 cycles, with `i_start` asserted during the DONE cycle.
- Reset mid-operation: `i_rst` wins over every other input. The FSM returns to IDLE on that edge, and all outputs take their reset values, including previously held results.
- `i_rst` and `i_start` in the same cycle: reset wins and the start is lost.

## Structure
- Shared arithmetic package `arith_pkg` holds:
  - the FSM state enum `sub_state_t` {IDLE, CALC, DONE};
  - a `MAX_BITS` = 32 constant, used for a parameter range assertion.
- One sub-module: `fullsubtractor_bit`, a combinational one-bit cell.
  - Inputs: `a`, `b`, `bw`.
  - Outputs: `d`, `bw_next`.
  - Instantiated once; it is reusable by future ripple subtractors.
- Top-level contents:
  - the FSM;
  - the counter;
  - the three shift registers;
  - the borrow flop;
  - the result and flag registers.

## Test plan
All scenarios use BITS=4.
- **5 − 3:** `i_a`=0101, `i_b`=0011 → after 5 cycles `o_diff`=0010, `o_borrow`=0, `o_overflow`=0, `o_done` pulses exactly once.
- **3 − 5:** `i_a`=0011, `i_b`=0101 → `o_diff`=1110, `o_borrow`=1, `o_overflow`=0.
- **Signed overflow:**
  - 0111 − 1111 (7 − (−1)) → `o_diff`=1000, `o_borrow`=1, `o_overflow`=1.
  - 1000 − 0001 → `o_diff`=0111, `o_borrow`=0, `o_overflow`=1.
- **Start while busy:** 0101 − 0011 started; `i_start`=1 with 1111 − 0001 two cycles later → ignored, result is 0010.
  - Then assert `i_start` with 1111 − 0001 during the DONE cycle → next result 1110 exactly 5 cycles later.
- **Reset mid-operation:** complete 0011 − 0101 (`o_diff`=1110), start 0101 − 0011, assert `i_rst` at cycle 2 of CALC → next cycle `o_busy`=0, `o_diff`=0000, flags 0, `o_done` never pulses.
  - A fresh start afterward then completes normally.
- **Randomized check:** 1000 random operand pairs checked against the reference model `a-b`, the unsigned compare and the sign rule.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state type and the widest supported operand.
package arith_pkg;

  localparam int unsigned MAX_BITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/fullsubtractor_bit.sv
// Combinational one-bit full subtractor cell: d = a - b - bw with borrow out.
module fullsubtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bw,
  output logic d,
  output logic bw_next
);

  always_comb begin
    d       = a ^ b ^ bw;
    bw_next = (~a & b) | (~(a ^ b) & bw);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one subtract cell reused BITS times.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned BITS = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [BITS-1:0] o_diff,
  output logic            o_borrow,
  output logic            o_overflow
);

  localparam int unsigned CntW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BITS - 1);

  if ((BITS < 2) || (BITS > MAX_BITS)) begin : gen_bits_check
    $error("serial_subtractor: BITS out of range 2..%0d", MAX_BITS);
  end

  sub_state_t      state_q, state_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  logic [BITS-1:0] r_q, r_d;
  logic [BITS-1:0] diff_q, diff_d;
  logic [1:0]      sign_q, sign_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bw_q, bw_d;
  logic            borrow_q, borrow_d;
  logic            ovf_q, ovf_d;
  logic            start_ok;
  logic            cell_d;
  logic            cell_bw;

  fullsubtractor_bit u_cell (
    .a       (a_q[0]),
    .b       (b_q[0]),
    .bw      (bw_q),
    .d       (cell_d),
    .bw_next (cell_bw)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    diff_d   = diff_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    bw_d     = bw_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    start_ok = i_start && (state_q != CALC);

    unique case (state_q)
      IDLE: begin
        if (i_start) state_d = CALC;
      end
      CALC: begin
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        r_d  = {cell_d, r_q[BITS-1:1]};
        bw_d = cell_bw;
        if (cnt_q == CntLast) begin
          state_d  = DONE;
          // Result registers take the final bit straight from the cell, not from r_q.
          diff_d   = {cell_d, r_q[BITS-1:1]};
          borrow_d = cell_bw;
          ovf_d    = (sign_q[1] != sign_q[0]) && (cell_d != sign_q[1]);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        state_d = i_start ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start_ok) begin
      a_d    = i_a;
      b_d    = i_b;
      sign_d = {i_a[BITS-1], i_b[BITS-1]};
      cnt_d  = '0;
      bw_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      diff_q   <= '0;
      sign_q   <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      diff_q   <= diff_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      bw_q     <= bw_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_busy     = (state_q == CALC);
  assign o_done     = (state_q == DONE);
  assign o_diff     = diff_q;
  assign o_borrow   = borrow_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases plus randomized operations.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_diff;
  logic         o_borrow;
  logic         o_overflow;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.BITS(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_a        (a),
    .i_b        (b),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_diff     (o_diff),
    .o_borrow   (o_borrow),
    .o_overflow (o_overflow)
  );

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    int   ux, uy, sx, sy, sd;
    exp_t e;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
    sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
    sd = sx - sy;
    e.diff   = W'(ux - uy);
    e.borrow = (ux < uy);
    e.ovf    = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic ov);
    exp_t e;
    e.diff   = d;
    e.borrow = bo;
    e.ovf    = ov;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (o_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got diff=%b with no result required", o_diff);
      end else begin
        e = sb_q.pop_front();
        check("diff", 32'(o_diff), 32'(e.diff));
        check("borrow", 32'(o_borrow), 32'(e.borrow));
        check("overflow", 32'(o_overflow), 32'(e.ovf));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    sb_q.push_back(e);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("busy_calc", 32'(o_busy), 32'd1);
      check("done_calc", 32'(o_done), 32'd0);
    end
    @(negedge clk);
    check("busy_at_done", 32'(o_busy), 32'd0);
    check("done_pulse", 32'(o_done), 32'd1);
  endtask

  initial begin
    int guard;
    logic [W-1:0] x, y;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_diff", 32'(o_diff), 32'd0);
    check("rst_borrow", 32'(o_borrow), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    rst = 1'b0;

    run_op(4'b0101, 4'b0011, mk(4'b0010, 1'b0, 1'b0));
    @(negedge clk);
    check("done_drop", 32'(o_done), 32'd0);
    run_op(4'b0011, 4'b0101, mk(4'b1110, 1'b1, 1'b0));
    run_op(4'b0111, 4'b1111, mk(4'b1000, 1'b1, 1'b1));
    run_op(4'b1000, 4'b0001, mk(4'b0111, 1'b0, 1'b1));

    // Start while busy is ignored; start during DONE runs back to back.
    @(negedge clk);
    start = 1'b1; a = 4'b0101; b = 4'b0011;
    sb_q.push_back(mk(4'b0010, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 4'b1111; b = 4'b0001;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_ignore_done", 32'(o_done), 32'd1);
    start = 1'b1; a = 4'b1111; b = 4'b0001;
    sb_q.push_back(mk(4'b1110, 1'b0, 1'b0));
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", 32'(o_busy), 32'd1);
    end
    @(negedge clk);
    check("b2b_done", 32'(o_done), 32'd1);

    // Reset mid-operation clears held results and suppresses done.
    run_op(4'b0011, 4'b0101, mk(4'b1110, 1'b1, 1'b0));
    @(negedge clk);
    start = 1'b1; a = 4'b0101; b = 4'b0011;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_done", 32'(o_done), 32'd0);
    check("mid_rst_diff", 32'(o_diff), 32'd0);
    check("mid_rst_borrow", 32'(o_borrow), 32'd0);
    check("mid_rst_overflow", 32'(o_overflow), 32'd0);
    repeat (W + 2) begin
      @(negedge clk);
      check("mid_rst_no_done", 32'(o_done), 32'd0);
    end
    run_op(4'b0101, 4'b0011, mk(4'b0010, 1'b0, 1'b0));

    // Randomized operations with ignored starts during CALC and random gaps.
    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      start = 1'b1;
      a     = x;
      b     = y;
      sb_q.push_back(model(x, y));
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (o_done !== 1'b1) begin
        if (guard > W + 2) begin
          tests++;
          fails++;
          $display("FAIL done_timeout: got no done after %0d cycles required %0d", guard, W);
          break;
        end
        if (o_busy && ($urandom_range(3) == 0)) begin
          start = 1'b1;
          a     = W'($urandom);
          b     = W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        guard++;
      end
      if ($urandom_range(1) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
    end

    repeat (W + 2) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
